countdown_100: RTL

Loadable down-counter over 0..99: the reverse of the up-counting `counter_100`. It accepts a start value through a valid/ready handshake and decrements once per enabled clock to zero. It then signals completion with a one-cycle done pulse. Count is presented as binary and as BCD tens/ones for the display path.

---
 rtl/countdown_100_if.sv | 29 ++
 rtl/countdown_100.sv | 123 ++++++++++++
 2 files changed

// File: rtl/countdown_100_if.sv
// Load/count bus of the countdown_100 down-counter: start-value handshake, run/abort controls, count and status.
// Latency: none (wires only).
// Backpressure: o_ready is the only flow control; requests while it is low are dropped, not queued.
interface countdown_100_if #(
    parameter int W = 7
);
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_num;
    logic         i_run;
    logic         i_abort;
    logic [W-1:0] o_cnt;
    logic [3:0]   o_tens;
    logic [3:0]   o_ones;
    logic         o_busy;
    logic         o_done;

    // Side that issues loads and controls, e.g. a sequencer or the bench.
    modport master (
        output i_valid, i_num, i_run, i_abort,
        input  o_ready, o_cnt, o_tens, o_ones, o_busy, o_done
    );

    // Side that implements the counter.
    modport slave (
        input  i_valid, i_num, i_run, i_abort,
        output o_ready, o_cnt, o_tens, o_ones, o_busy, o_done
    );
endinterface

// File: rtl/countdown_100.sv
// Loadable 0..MAX down-counter with one-cycle done pulse and BCD tens/ones view; optional COUNTDOWN_AUTO_RELOAD_EN macro.
// Latency: count visible the edge after load; done pulses v+1 enabled edges after a load of v.
// Backpressure: o_ready high only in IDLE; loads while busy are ignored, i_run low freezes the count.
module countdown_100 #(
    parameter int MAX = 99,
    parameter int W   = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    countdown_100_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX_W = W'(MAX);
    localparam logic [W-1:0] ONE_W = W'(1);
    localparam logic [W-1:0] TEN_W = W'(10);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q,   cnt_d;
    logic         done_q,  done_d;
    logic [W-1:0] num_clamp;

    // Oversized requests saturate at MAX; the whole W-bit request is compared.
    assign num_clamp = (bus.i_num > MAX_W) ? MAX_W : bus.i_num;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Start value is kept so a terminal count can restart the period.
    logic [W-1:0] load_q, load_d;

    // State, count, done pulse and stored start value registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            load_q  <= load_d;
        end
    end
`else
    // State, count and done pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
`endif

    // Next state, next count and done pulse; abort overrides everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        load_d  = load_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    cnt_d   = num_clamp;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    load_d  = num_clamp;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.i_run) begin
                    if (cnt_q != '0) begin
                        // Never decremented at zero, so no wrap is possible.
                        cnt_d = cnt_q - ONE_W;
                    end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        // Periodic mode: restart from the stored value and stay in RUN.
                        cnt_d   = load_q;
`else
                        state_d = ST_DONE;
`endif
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        if (bus.i_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_busy  = (state_q != ST_IDLE);
    assign bus.o_cnt   = cnt_q;
    assign bus.o_done  = done_q;

    // Display path: decimal digits of the registered count (valid for counts up to 99).
    assign bus.o_tens  = 4'(cnt_q / TEN_W);
    assign bus.o_ones  = 4'(cnt_q % TEN_W);

endmodule
